// File: rtl/switch_input_pkg.sv
// Shared types for the key event scheduler: event record, key index width and
// scan FSM states.
package switch_input_pkg;

  // Wide enough for the largest supported key bank (16 keys).
  localparam int KEY_IDX_W = 4;

  typedef struct packed {
    logic                 pressed;
    logic [KEY_IDX_W-1:0] key;
  } key_event_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through event queue with count-based full/empty and a
// drop indication when a push meets a full queue that is not popping.
module key_event_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0]
) (
  input  logic clock,
  input  logic reset_n,
  input  logic push,
  input  T     push_data,
  output logic push_drop,
  input  logic pop_ready,
  output logic valid,
  output T     head
);

  localparam int PTR_W = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("key_event_fifo: DEPTH must be a power of two >= 2");
  end

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             pop;
  logic             do_push;

  assign valid     = (count != '0);
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign pop       = valid & pop_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push   = push & (~full | pop);
  assign push_drop = push & full & ~pop;
  assign head      = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_scheduler.sv
// Time-multiplexed debounce for a bank of front-panel keys: one filter datapath
// visits every key once per sampling period and queues settled edges as events.
module key_event_scheduler
  import switch_input_pkg::*;
#(
  parameter int N_KEYS         = 8,
  parameter int SAMPLE_DIVIDER = 1200,
  parameter int FILTER_COUNT   = 3,
  parameter int EVENT_DEPTH    = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [N_KEYS-1:0]         key_in,
  output logic [N_KEYS-1:0]         key_state,
  output logic                      event_valid,
  input  logic                      event_ready,
  output logic                      event_pressed,
  output logic [$clog2(N_KEYS)-1:0] event_key,
  output logic                      overflow,
  input  logic                      overflow_clear,
  output logic                      scan_active
);

  // Handshake: an event transfers on every clock where event_valid and
  // event_ready are both high; while valid and not ready the head holds steady.

  localparam int IDX_W = $clog2(N_KEYS);
  localparam int CNT_W = $clog2(FILTER_COUNT + 1);
  localparam int TMR_W = $clog2(SAMPLE_DIVIDER);

  if (SAMPLE_DIVIDER < N_KEYS + 2) begin : g_div_check
    $error("key_event_scheduler: SAMPLE_DIVIDER must be at least N_KEYS+2");
  end
  if (N_KEYS < 2 || N_KEYS > 16 || FILTER_COUNT < 1 || FILTER_COUNT > 15) begin : g_range_check
    $error("key_event_scheduler: N_KEYS or FILTER_COUNT out of range");
  end

  logic [N_KEYS-1:0] key_meta;
  logic [N_KEYS-1:0] key_sync;
  logic [TMR_W-1:0]  timer;
  logic              tick;
  scan_state_t       state, state_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [CNT_W-1:0]  cnt [N_KEYS];
  logic              cur_sync;
  logic              cur_level;
  logic [CNT_W-1:0]  cur_cnt;
  logic              accept;
  logic              drop;
  key_event_t        push_event;
  key_event_t        head;
  logic              unused_key_bits;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_meta <= '0;
      key_sync <= '0;
    end else begin
      key_meta <= key_in;
      key_sync <= key_meta;
    end
  end

  assign tick = enable && (timer == TMR_W'(SAMPLE_DIVIDER - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     timer <= '0;
    else if (!enable) timer <= '0;
    else if (tick)    timer <= '0;
    else              timer <= timer + 1'b1;
  end

  // A pass, once started, always runs to the last key regardless of enable.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    case (state)
      IDLE: if (tick) begin
        state_d = SCAN;
        idx_d   = '0;
      end
      SCAN: if (idx == IDX_W'(N_KEYS - 1)) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  assign scan_active = (state == SCAN);
  assign cur_sync    = key_sync[idx];
  assign cur_level   = key_state[idx];
  assign cur_cnt     = cnt[idx];
  assign accept      = scan_active && (cur_sync != cur_level) &&
                       (cur_cnt == CNT_W'(FILTER_COUNT - 1));

  always_comb begin
    push_event         = '0;
    push_event.pressed = cur_sync;
    push_event.key     = KEY_IDX_W'(idx);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_state <= '0;
      for (int i = 0; i < N_KEYS; i++) cnt[i] <= '0;
    end else if (scan_active) begin
      if (cur_sync == cur_level) begin
        cnt[idx] <= '0;
      end else if (accept) begin
        key_state[idx] <= cur_sync;
        cnt[idx]       <= '0;
      end else begin
        cnt[idx] <= cur_cnt + 1'b1;
      end
    end
  end

  key_event_fifo #(
    .DEPTH (EVENT_DEPTH),
    .T     (key_event_t)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (accept),
    .push_data (push_event),
    .push_drop (drop),
    .pop_ready (event_ready),
    .valid     (event_valid),
    .head      (head)
  );

  assign event_pressed   = head.pressed;
  assign event_key       = head.key[IDX_W-1:0];
  assign unused_key_bits = ^head.key;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)            overflow <= 1'b0;
    else if (overflow_clear) overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
  end

endmodule

// File: tb/tb_key_event_scheduler.sv
// Bench for key_event_scheduler: cycle-level behavioural model with an event
// queue, directed scenarios with literal expectations, then random stimulus.
module tb_key_event_scheduler;

  localparam int N     = 8;
  localparam int DIV   = 16;
  localparam int FC    = 3;
  localparam int DEPTH = 4;

  logic       clock          = 1'b0;
  logic       reset_n        = 1'b0;
  logic       enable         = 1'b0;
  logic [7:0] key_in         = '0;
  logic       event_ready    = 1'b0;
  logic       overflow_clear = 1'b0;
  logic [7:0] key_state;
  logic       event_valid;
  logic       event_pressed;
  logic [2:0] event_key;
  logic       overflow;
  logic       scan_active;

  int n_checks = 0;
  int n_fail   = 0;

  key_event_scheduler #(
    .N_KEYS(N), .SAMPLE_DIVIDER(DIV), .FILTER_COUNT(FC), .EVENT_DEPTH(DEPTH)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .key_in         (key_in),
    .key_state      (key_state),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_pressed  (event_pressed),
    .event_key      (event_key),
    .overflow       (overflow),
    .overflow_clear (overflow_clear),
    .scan_active    (scan_active)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // behavioural model: state after each clock edge
  int         m_tmr = 0;
  int         m_pos = -1;
  int         m_cnt [N];
  logic [7:0] m_state = '0;
  logic [7:0] m_s1 = '0;
  logic [7:0] m_s2 = '0;
  logic       m_ovf = 1'b0;
  logic [3:0] exp_q [$];
  bit         m_pop, m_push, m_tick, m_drop;
  logic [3:0] m_ev;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_tmr = 0; m_pos = -1; m_state = '0; m_s1 = '0; m_s2 = '0; m_ovf = 1'b0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      exp_q.delete();
    end else begin
      m_pop  = (exp_q.size() != 0) && event_ready;
      m_push = 1'b0;
      m_drop = 1'b0;
      m_ev   = '0;
      if (m_pos >= 0) begin
        if (m_s2[m_pos] == m_state[m_pos]) m_cnt[m_pos] = 0;
        else if (m_cnt[m_pos] == FC - 1) begin
          m_state[m_pos] = m_s2[m_pos];
          m_cnt[m_pos]   = 0;
          m_push         = 1'b1;
          m_ev           = {m_s2[m_pos], 3'(m_pos)};
        end else m_cnt[m_pos] = m_cnt[m_pos] + 1;
      end
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(m_ev);
        else m_drop = 1'b1;
      end
      if (overflow_clear) m_ovf = 1'b0;
      else if (m_drop)    m_ovf = 1'b1;
      m_tick = enable && (m_tmr == DIV - 1);
      m_tmr  = (!enable || m_tick) ? 0 : m_tmr + 1;
      if (m_pos >= 0) m_pos = (m_pos == N - 1) ? -1 : m_pos + 1;
      else if (m_tick) m_pos = 0;
      m_s2 = m_s1;
      m_s1 = key_in;
    end
  end

  // compare process plus observed-event log
  logic [3:0] cmp_head;
  logic [3:0] obs_q [$];

  always @(negedge clock) begin
    cmp_head = (exp_q.size() != 0) ? exp_q[0] : 4'h0;
    check("key_state",     key_state,     m_state);
    check("event_valid",   event_valid,   exp_q.size() != 0);
    check("event_pressed", event_pressed, cmp_head[3]);
    check("event_key",     event_key,     cmp_head[2:0]);
    check("overflow",      overflow,      m_ovf);
    check("scan_active",   scan_active,   m_pos >= 0);
    if (reset_n && event_valid && event_ready) obs_q.push_back({event_pressed, event_key});
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    reset_n = 1'b0; enable = 1'b0; key_in = '0; event_ready = 1'b0; overflow_clear = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    obs_q.delete();
  endtask

  int guard;

  initial begin
    step();
    step();
    reset_n = 1'b1;
    check("rst_key_state", key_state, 8'h00);
    check("rst_valid", event_valid, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_key", event_key, 3'd0);
    check("rst_pressed", event_pressed, 1'b0);

    // 1: single held key settles into one press event
    do_reset();
    enable = 1'b1; event_ready = 1'b1; key_in[5] = 1'b1;
    repeat (4 * DIV) step();
    check("s1_count", obs_q.size(), 1);
    if (obs_q.size() >= 1) check("s1_event", obs_q[0], 4'hD);
    check("s1_key_state", key_state, 8'h20);

    // 2: half-period equal to the sampling period, so consecutive samples alternate
    do_reset();
    enable = 1'b1; event_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      key_in[2] = ~key_in[2];
      repeat (DIV) step();
    end
    check("s2_count", obs_q.size(), 0);
    check("s2_key2", key_state[2], 1'b0);

    // 3: simultaneous presses come out in ascending index order
    do_reset();
    enable = 1'b1; event_ready = 1'b1; key_in = 8'b1001_0010;
    repeat (5 * DIV) step();
    check("s3_count", obs_q.size(), 3);
    if (obs_q.size() >= 3) begin
      check("s3_ev0", obs_q[0], 4'h9);
      check("s3_ev1", obs_q[1], 4'hC);
      check("s3_ev2", obs_q[2], 4'hF);
    end

    // 4: five presses into a depth-4 queue with the consumer stalled
    do_reset();
    enable = 1'b1; key_in = 8'h1F;
    repeat (5 * DIV) step();
    check("s4_overflow", overflow, 1'b1);
    check("s4_key_state", key_state, 8'h1F);
    check("s4_valid", event_valid, 1'b1);
    overflow_clear = 1'b1;
    step();
    overflow_clear = 1'b0;
    check("s4_cleared", overflow, 1'b0);
    event_ready = 1'b1;
    repeat (8) step();
    check("s4_count", obs_q.size(), 4);
    if (obs_q.size() >= 4) begin
      check("s4_ev0", obs_q[0], 4'h8);
      check("s4_ev3", obs_q[3], 4'hB);
    end

    // 5: full queue, pop on the same edge as the next push
    do_reset();
    enable = 1'b1; key_in = 8'h1F;
    guard = 0;
    while (!(m_pos == 4 && m_cnt[4] == FC - 1 && exp_q.size() == DEPTH) && guard < 200) begin
      step();
      guard++;
    end
    check("s5_reached", guard < 200, 1'b1);
    event_ready = 1'b1;
    step();
    event_ready = 1'b0;
    check("s5_overflow", overflow, 1'b0);
    check("s5_key_state", key_state, 8'h1F);
    event_ready = 1'b1;
    repeat (8) step();
    check("s5_count", obs_q.size(), 5);
    if (obs_q.size() >= 5) begin
      check("s5_ev0", obs_q[0], 4'h8);
      check("s5_ev4", obs_q[4], 4'hC);
    end

    // 6: reset in the middle of a pass with two events queued
    do_reset();
    enable = 1'b1; key_in = 8'h03;
    guard = 0;
    while (!(m_pos == 4 && exp_q.size() == 2) && guard < 200) begin
      step();
      guard++;
    end
    check("s6_reached", guard < 200, 1'b1);
    check("s6_pre_valid", event_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    check("s6_valid", event_valid, 1'b0);
    check("s6_key_state", key_state, 8'h00);
    check("s6_key", event_key, 3'd0);
    check("s6_pressed", event_pressed, 1'b0);
    check("s6_overflow", overflow, 1'b0);
    step();
    reset_n = 1'b1;
    obs_q.delete();
    repeat (2 * DIV) step();
    check("s6_no_early", event_valid, 1'b0);
    event_ready = 1'b1;
    repeat (5 * DIV) step();
    check("s6_count", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      check("s6_ev0", obs_q[0], 4'h8);
      check("s6_ev1", obs_q[1], 4'h9);
    end

    // random phase: bouncing keys, stalling consumer, enable glitches, clears
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) if ($urandom_range(0, 59) == 0) key_in[k] = ~key_in[k];
      if (((c / 400) % 2) == 1) event_ready = ($urandom_range(0, 7) == 0);
      else                      event_ready = ($urandom_range(0, 3) != 0);
      enable         = ($urandom_range(0, 99) != 0);
      overflow_clear = ($urandom_range(0, 79) == 0);
      if (c == 1500) reset_n = 1'b0;
      if (c == 1502) reset_n = 1'b1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
